playback_sequencer: RTL
=======================

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning maximum stored sequence length in notes (power of two, 2..64).
REQ-002 SHALL have parameter ON_TICKS, default 3000, meaning lamp-on cycles per note (300 ms at 10 kHz).
REQ-003 SHALL have parameter OFF_TICKS, default 1000, meaning dark-gap cycles after each note.
REQ-004 SHALL have port CLK  input  1  single clock for all state (10 kHz game clock).
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port CLR  input  1  clears the sequence and aborts playback.
REQ-007 SHALL have port APPEND  input  1  one-cycle request to append APPEND_NOTE.
REQ-008 SHALL have port APPEND_NOTE  input  2  note (0..3) to append.
REQ-009 SHALL have port PLAY  input  1  one-cycle request to play the stored sequence.
REQ-010 SHALL have port RD_IDX  input  log2(DEPTH)  read index for input checking.
REQ-011 SHALL have port RD_NOTE  output  2  stored note at RD_IDX, combinational.
REQ-012 SHALL have port OUT  output  2  note currently driven to lamps/oscillator.
REQ-013 SHALL have port OUT_ENA  output  1  lamp/tone enable.
REQ-014 SHALL have port BUSY  output  1  high while playback in progress.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse when playback completes.
REQ-016 SHALL have port LEN  output  log2(DEPTH)+1  number of stored notes.
REQ-017 SHALL have port FULL  output  1  high when LEN == DEPTH.

Function
REQ-018 SHALL implement FSM states IDLE, LAMP_ON, LAMP_OFF; all outputs registered except RD_NOTE and FULL (decoded from LEN).
REQ-019 SHALL, in IDLE, on PLAY with effective LEN>0, set index to 0, load timer ON_TICKS-1, enter LAMP_ON next cycle.
REQ-020 SHALL drive OUT=mem[index] and OUT_ENA=1 for exactly ON_TICKS cycles in LAMP_ON, then enter LAMP_OFF with OUT_ENA=0 for exactly OFF_TICKS cycles.
REQ-021 SHALL, at end of LAMP_OFF, if index==LEN-1 return to IDLE and pulse DONE for one cycle, else increment index and re-enter LAMP_ON.
REQ-022 SHALL assert BUSY throughout LAMP_ON and LAMP_OFF and deassert it in the cycle DONE pulses.
REQ-023 SHALL, on PLAY with LEN==0 and no simultaneous APPEND, stay IDLE and pulse DONE the next cycle with OUT_ENA kept 0.
REQ-024 SHALL accept APPEND only in IDLE with FULL==0: write mem[LEN]=APPEND_NOTE, LEN+1 next cycle.
REQ-025 SHALL ignore APPEND when FULL or BUSY (no write, LEN unchanged) and ignore PLAY while BUSY.
REQ-026 SHALL accept simultaneous APPEND and PLAY in IDLE; playback covers post-append length (LEN 0 -> plays 1 note).
REQ-027 SHALL, on CLR, set LEN=0, go IDLE, OUT_ENA=0, BUSY=0 next cycle, without DONE; CLR has priority over APPEND and PLAY.
REQ-028 SHALL hold OUT at last played note when OUT_ENA=0 (value don't-care to consumers).
REQ-029 SHALL keep memory contents unchanged by CLR; only LEN is cleared.

Reset
REQ-030 SHALL, while RST=1, force state IDLE, LEN=0, index=0, timer=0, OUT=0, OUT_ENA=0, BUSY=0, DONE=0, FULL=0 asynchronously.
REQ-031 SHALL abort any playback on RST mid-operation with no DONE pulse; memory contents need not be reset.
REQ-032 SHALL resume normal operation on the first CLK edge after RST deasserts.

Configuration
REQ-033 SHALL support macro SEQ_SPEEDUP_EN: when defined, notes play for ON_TICKS/2 (integer) cycles and gaps for OFF_TICKS/2 cycles whenever LEN>=8; when undefined, durations are always ON_TICKS/OFF_TICKS.

Verification (ON_TICKS=4, OFF_TICKS=2, DEPTH=4 unless noted)
REQ-034 SHALL cover: append 2,1,3 then PLAY -> OUT_ENA high 4 cycles each with OUT=2,1,3, 2-cycle gaps, DONE pulse once after 18 cycles, BUSY low thereafter.
REQ-035 SHALL cover: append 4 notes then APPEND 0 -> FULL=1, LEN stays 4, mem unchanged.
REQ-036 SHALL cover: PLAY with LEN=0 -> DONE pulse next cycle, OUT_ENA never high; PLAY+APPEND 3 at LEN=0 -> one note OUT=3 played.
REQ-037 SHALL cover: CLR during second LAMP_ON -> next cycle OUT_ENA=0, BUSY=0, LEN=0, no DONE; RST asserted mid-playback -> same, asynchronously.
REQ-038 SHALL cover: with SEQ_SPEEDUP_EN, DEPTH=16, ON_TICKS=4, 8 notes -> each note 2 cycles on, 1 cycle off; at 7 notes -> 4 on, 2 off.

Source files
------------

// File: rtl/playback_sequencer.sv
// Note-sequence recorder/player: appends 2-bit notes, then plays them with timed lamp-on/gap phases.
// Optional SEQ_SPEEDUP_EN: halves on/gap durations once the sequence holds 8 or more notes.
module playback_sequencer #(
  parameter int DEPTH     = 32,
  parameter int ON_TICKS  = 3000,
  parameter int OFF_TICKS = 1000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic                     APPEND,
  input  logic [1:0]               APPEND_NOTE,
  input  logic                     PLAY,
  input  logic [$clog2(DEPTH)-1:0] RD_IDX,
  output logic [1:0]               RD_NOTE,
  output logic [1:0]               OUT,
  output logic                     OUT_ENA,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [$clog2(DEPTH):0]   LEN,
  output logic                     FULL
);

  localparam int AW       = $clog2(DEPTH);
  localparam int LW       = AW + 1;
  localparam int TMAX     = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW       = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int ON_HALF  = (ON_TICKS / 2 > 0) ? ON_TICKS / 2 : 1;
  localparam int OFF_HALF = (OFF_TICKS / 2 > 0) ? OFF_TICKS / 2 : 1;

  localparam logic [TW-1:0] ON_M1       = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_M1      = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] ON_HALF_M1  = TW'(ON_HALF - 1);
  localparam logic [TW-1:0] OFF_HALF_M1 = TW'(OFF_HALF - 1);

  typedef enum logic [1:0] {IDLE, LAMP_ON, LAMP_OFF} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d, idx_nx;
  logic [TW-1:0]   timer_q, timer_d, on_load, off_load;
  logic [LW-1:0]   len_d, len_eff;
  logic [1:0]      out_d;
  logic            ena_d, busy_d, done_d;
  logic            append_ok, fast, last_note;
  logic [1:0]      mem [DEPTH];

  assign FULL      = (LEN == LW'(DEPTH));
  assign RD_NOTE   = mem[RD_IDX];
  assign append_ok = (state_q == IDLE) && APPEND && !FULL;
  // Length as seen by a PLAY in the same cycle as an accepted APPEND
  assign len_eff   = LEN + LW'(append_ok);
  assign idx_nx    = idx_q + AW'(1);
  assign last_note = ({1'b0, idx_q} == (LEN - LW'(1)));

`ifdef SEQ_SPEEDUP_EN
  assign fast = (32'(len_eff) >= 32'd8);
`else
  assign fast = 1'b0;
`endif
  assign on_load  = fast ? ON_HALF_M1 : ON_M1;
  assign off_load = fast ? OFF_HALF_M1 : OFF_M1;

  always_ff @(posedge CLK) begin
    if (append_ok && !CLR) mem[LEN[AW-1:0]] <= APPEND_NOTE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      LEN     <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      OUT     <= '0;
      OUT_ENA <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      LEN     <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      OUT     <= out_d;
      OUT_ENA <= ena_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = LEN;
    idx_d   = idx_q;
    timer_d = timer_q;
    out_d   = OUT;
    ena_d   = OUT_ENA;
    busy_d  = BUSY;
    done_d  = 1'b0;
    if (CLR) begin
      state_d = IDLE;
      len_d   = '0;
      ena_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          len_d = len_eff;
          if (PLAY) begin
            if (len_eff == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = LAMP_ON;
              idx_d   = '0;
              timer_d = on_load;
              ena_d   = 1'b1;
              busy_d  = 1'b1;
              // Slot 0 is still being written when PLAY and the first APPEND coincide
              out_d   = (append_ok && LEN == '0) ? APPEND_NOTE : mem['0];
            end
          end
        end
        LAMP_ON: begin
          if (timer_q == '0) begin
            state_d = LAMP_OFF;
            ena_d   = 1'b0;
            timer_d = off_load;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        LAMP_OFF: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (last_note) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = LAMP_ON;
            idx_d   = idx_nx;
            out_d   = mem[idx_nx];
            ena_d   = 1'b1;
            timer_d = on_load;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
